alu_cmd_issuer: RTL and testbench

//  Initiator side of the 32-bit ALU interface. It accepts operation commands over a valid/ready channel.
//  It decodes each command's function code to the 4-bit ALU opcode and drives A/B/opcode from registers.
//  It captures result and zero into an in-order response FIFO, returned over a second valid/ready channel.

---
 rtl/alu_cmd_issuer.sv | 161 ++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Issues decoded commands to a combinational 32-bit ALU through a one-entry stage register and
// returns the results, in order, from a response FIFO.
module alu_cmd_issuer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_fn,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW:0] DepthC = (CntW + 1)'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  // Decode
  logic [3:0] dec_op;
  logic       dec_err;
  logic       dec_cmpeq;

  always_comb begin
    dec_op    = 4'b0000;
    dec_err   = 1'b0;
    dec_cmpeq = 1'b0;
    case (cmd_fn)
      4'd0: dec_op = 4'b0000;
      4'd1: dec_op = 4'b0001;
      4'd2: dec_op = 4'b0100;
      4'd3: dec_op = 4'b0101;
      4'd4: dec_op = 4'b0110;
      4'd5: dec_op = 4'b0111;
      4'd6: dec_op = 4'b0010;
      4'd7: begin
        dec_op    = 4'b0001;
        dec_cmpeq = 1'b1;
      end
      default: dec_err = 1'b1;
    endcase
  end

  // Stage register
  logic             stage_valid_q;
  logic [31:0]      stage_a_q;
  logic [31:0]      stage_b_q;
  logic [3:0]       stage_op_q;
  logic             stage_err_q;
  logic             stage_cmpeq_q;
  logic [TAG_W-1:0] stage_tag_q;
  logic             accept;

  logic [CntW-1:0]  count_q;
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW:0]    occupancy;

  // Counting the stage entry guarantees a FIFO slot for it, so the stage never stalls.
  assign occupancy = {1'b0, count_q} + {{CntW{1'b0}}, stage_valid_q};
  assign cmd_ready = occupancy < DepthC;
  assign accept    = cmd_valid & cmd_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid_q <= 1'b0;
      stage_a_q     <= '0;
      stage_b_q     <= '0;
      stage_op_q    <= '0;
      stage_err_q   <= 1'b0;
      stage_cmpeq_q <= 1'b0;
      stage_tag_q   <= '0;
    end else begin
      stage_valid_q <= accept;
      if (accept) begin
        stage_a_q     <= cmd_a;
        stage_b_q     <= cmd_b;
        stage_op_q    <= dec_op;
        stage_err_q   <= dec_err;
        stage_cmpeq_q <= dec_cmpeq;
        stage_tag_q   <= cmd_tag;
      end
    end
  end

  logic drive_alu;
  assign drive_alu  = stage_valid_q & ~stage_err_q;
  assign alu_a      = drive_alu ? stage_a_q : 32'h0;
  assign alu_b      = drive_alu ? stage_b_q : 32'h0;
  assign alu_opcode = drive_alu ? stage_op_q : 4'b0000;

  // Response FIFO
  logic        push;
  logic        pop;
  logic [31:0] push_result;
  logic        push_zero;

  assign push = stage_valid_q;
  assign pop  = rsp_valid & rsp_ready;

  always_comb begin
    push_result = alu_result;
    push_zero   = alu_zero;
    if (stage_err_q) begin
      push_result = 32'h0;
      push_zero   = 1'b1;
    end else if (stage_cmpeq_q) begin
      push_result = {31'b0, alu_zero};
    end
  end

  logic [31:0]      res_mem  [DEPTH];
  logic             zero_mem [DEPTH];
  logic             err_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem  [DEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[wr_ptr_q]  <= push_result;
      zero_mem[wr_ptr_q] <= push_zero;
      err_mem[wr_ptr_q]  <= stage_err_q;
      tag_mem[wr_ptr_q]  <= stage_tag_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (!push && pop) count_q <= count_q - CntW'(1);
    end
  end

  assign rsp_valid  = count_q != '0;
  assign rsp_result = rsp_valid ? res_mem[rd_ptr_q] : 32'h0;
  assign rsp_zero   = rsp_valid ? zero_mem[rd_ptr_q] : 1'b0;
  assign rsp_err    = rsp_valid ? err_mem[rd_ptr_q] : 1'b0;
  assign rsp_tag    = rsp_valid ? tag_mem[rd_ptr_q] : '0;
  assign busy       = stage_valid_q | rsp_valid;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural combinational ALU attached.
module tb_alu_cmd_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_fn;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  cmd_tag;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;
  logic [3:0]  rsp_tag;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DEPTH(4), .TAG_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_fn     (cmd_fn),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_tag    (cmd_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .rsp_tag    (rsp_tag),
    .busy       (busy)
  );

  always_comb begin
    alu_result = 32'h0;
    case (alu_opcode)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'b0100: alu_result = alu_a & alu_b;
      4'b0101: alu_result = alu_a | alu_b;
      4'b0110: alu_result = alu_a ^ alu_b;
      4'b0111: alu_result = ~(alu_a | alu_b);
      default: alu_result = 32'h0;
    endcase
    alu_zero = alu_result == 32'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag);
    cmd_valid = 1'b1;
    cmd_fn    = fn;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
  endtask

  typedef struct {
    logic [3:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [3:0]  op;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] l_exp [4];
    logic [3:0]  l_op  [4];
    int          next_tag;

    vecs[0] = '{fn: 4'd0, a: 32'd5,        b: 32'd7, tag: 4'd3, op: 4'b0000, res: 32'd12, zero: 1'b0, err: 1'b0};
    vecs[1] = '{fn: 4'd7, a: 32'd9,        b: 32'd9, tag: 4'd1, op: 4'b0001, res: 32'd1,  zero: 1'b1, err: 1'b0};
    vecs[2] = '{fn: 4'd7, a: 32'd9,        b: 32'd8, tag: 4'd2, op: 4'b0001, res: 32'd0,  zero: 1'b0, err: 1'b0};
    vecs[3] = '{fn: 4'd1, a: 32'd9,        b: 32'd9, tag: 4'd4, op: 4'b0001, res: 32'd0,  zero: 1'b1, err: 1'b0};
    vecs[4] = '{fn: 4'hA, a: 32'd11,       b: 32'd3, tag: 4'd7, op: 4'b0000, res: 32'd0,  zero: 1'b1, err: 1'b1};
    vecs[5] = '{fn: 4'd6, a: 32'hFFFFFFFF, b: 32'd1, tag: 4'd5, op: 4'b0010, res: 32'd1,  zero: 1'b0, err: 1'b0};
    vecs[6] = '{fn: 4'd0, a: 32'hFFFFFFFF, b: 32'd1, tag: 4'd9, op: 4'b0000, res: 32'd0,  zero: 1'b1, err: 1'b0};
    vecs[7] = '{fn: 4'hF, a: 32'd1,        b: 32'd2, tag: 4'hE, op: 4'b0000, res: 32'd0,  zero: 1'b1, err: 1'b1};

    reset = 1'b1; cmd_valid = 1'b0; cmd_fn = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_busy", busy, 0);

    // Single commands with a free-running consumer
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_cmd(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].tag);
      chk("vec_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("vec_alu_opcode", alu_opcode, vecs[i].op);
      chk("vec_alu_a", alu_a, vecs[i].err ? 32'h0 : vecs[i].a);
      chk("vec_alu_b", alu_b, vecs[i].err ? 32'h0 : vecs[i].b);
      chk("vec_early_valid", rsp_valid, 0);
      chk("vec_busy", busy, 1);
      @(negedge clk);
      chk("vec_alu_idle", alu_opcode, 0);
      chk("vec_rsp_valid", rsp_valid, 1);
      chk("vec_rsp_result", rsp_result, vecs[i].res);
      chk("vec_rsp_zero", rsp_zero, vecs[i].zero);
      chk("vec_rsp_err", rsp_err, vecs[i].err);
      chk("vec_rsp_tag", rsp_tag, 32'(vecs[i].tag));
      @(negedge clk);
      chk("vec_drained", rsp_valid, 0);
      chk("vec_idle", busy, 0);
    end

    // Back-to-back logic ops, one response per cycle
    l_exp[0] = 32'hF000F000; l_exp[1] = 32'hFFF0FFF0;
    l_exp[2] = 32'h0FF00FF0; l_exp[3] = 32'h000F000F;
    l_op[0] = 4'b0100; l_op[1] = 4'b0101; l_op[2] = 4'b0110; l_op[3] = 4'b0111;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        drive_cmd(4'(i + 2), 32'hF0F0F0F0, 32'hFF00FF00, 4'(i));
        chk("b2b_cmd_ready", cmd_ready, 1);
      end else begin
        cmd_valid = 1'b0;
      end
      if (i >= 1 && i <= 4) chk("b2b_alu_opcode", alu_opcode, l_op[i-1]);
      if (i >= 2) begin
        chk("b2b_rsp_valid", rsp_valid, 1);
        chk("b2b_rsp_result", rsp_result, l_exp[i-2]);
        chk("b2b_rsp_tag", rsp_tag, 32'(i - 2));
      end
      @(negedge clk);
    end
    chk("b2b_drained", rsp_valid, 0);

    // Backpressure: fill with tags 0..5 offered, consumer stalled
    rsp_ready = 1'b0;
    next_tag  = 0;
    for (int c = 0; c < 8; c++) begin
      drive_cmd(4'd0, 32'(next_tag), 32'h0, 4'(next_tag));
      if (cmd_ready) next_tag++;
      if (rsp_valid) chk("bp_head_stable", rsp_tag, 0);
      @(negedge clk);
    end
    chk("bp_accepted", 32'(next_tag), 4);
    chk("bp_cmd_ready_low", cmd_ready, 0);
    chk("bp_head_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_tag", rsp_tag, 32'(k));
      chk("bp_rsp_result", rsp_result, 32'(k));
      if (next_tag < 6) begin
        drive_cmd(4'd0, 32'(next_tag), 32'h0, 4'(next_tag));
        if (cmd_ready) next_tag++;
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("bp_drained", rsp_valid, 0);
    chk("bp_idle", busy, 0);

    // Reset with three ops outstanding
    rsp_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive_cmd(4'd0, 32'(i), 32'd1, 4'(i));
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("mid_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_async_valid", rsp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_cmd_ready", cmd_ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_alu_opcode", alu_opcode, 0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("mid_no_ghost", rsp_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
